// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared state encoding and default sizes for the hold arbiter
package bpu_pkg;

  typedef enum logic {
    HA_EMPTY = 1'b0,
    HA_FULL  = 1'b1
  } ha_state_e;

  localparam int HA_N_REQ = 4;
  localparam int HA_W     = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner select starting at rr_ptr
module rr_pick
  import bpu_pkg::*;
#(
  parameter int N_REQ = HA_N_REQ,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int          cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Scan upward from the pointer, wrapping; the first hit wins.
    for (int k = 0; k < N_REQ; k++) begin
      cand     = (int'(rr_ptr) + k) % N_REQ;
      cand_idx = IW'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/hold_arbiter.sv
// rtl/hold_arbiter.sv - N-way round-robin arbiter feeding a single-entry hold slot
module hold_arbiter
  import bpu_pkg::*;
#(
  parameter int N_REQ = HA_N_REQ,
  parameter int W     = HA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W-1:0]         req_data,
  output logic [N_REQ-1:0]           req_grant,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  output logic [$clog2(N_REQ)-1:0]   out_src,
  input  logic                       out_ack
);

  localparam int IW = $clog2(N_REQ);

  ha_state_e        state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [IW-1:0]    src_q, src_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             load;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Reset suppresses the grant so nothing is acknowledged to a requester and then dropped.
  assign load      = pick_any && (state_q == HA_EMPTY || out_ack) && !rst;
  assign req_grant = load ? pick_grant : '0;

  assign out_valid = (state_q == HA_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    src_d    = src_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      state_d  = HA_FULL;
      data_d   = req_data[int'(pick_idx)*W +: W];
      src_d    = pick_idx;
      rr_ptr_d = (int'(pick_idx) == N_REQ-1) ? '0 : pick_idx + 1'b1;
    end else if (state_q == HA_FULL && out_ack) begin
      state_d = HA_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HA_EMPTY;
      data_q   <= '0;
      src_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
